// File: rtl/filter_pkg.sv
// Shared types and reset-default coefficients for the time-multiplexed IIR sequencer.
// Coefficients are signed Q16 words; ch0 is the low-pass set, ch1 the high-pass set.
package filter_pkg;

  localparam int COEF_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_B0,
    ST_B1,
    ST_A1,
    ST_EMIT,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    SEL_B0   = 2'd0,
    SEL_B1   = 2'd1,
    SEL_A1   = 2'd2,
    SEL_RSVD = 2'd3
  } coef_sel_t;

  typedef struct packed {
    logic [COEF_W-1:0] b0;
    logic [COEF_W-1:0] b1;
    logic [COEF_W-1:0] a1;
  } coef_t;

  localparam coef_t LP_COEF_DEFAULT = '{
    b0: 32'h0000_0080,
    b1: 32'h0000_0080,
    a1: 32'h0000_FEFF
  };

  localparam coef_t HP_COEF_DEFAULT = '{
    b0: 32'h0000_E01A,
    b1: 32'hFFFF_1FE6,
    a1: 32'h0000_C035
  };

endpackage

// File: rtl/iir_mac.sv
// Signed multiply-accumulate with a double-width wrapping accumulator; clr beats en.
// y is the registered accumulator scaled back to Q(FRAC_BITS); y_nxt is the value it takes next edge.
module iir_mac #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic        [DATA_W-1:0] y,
  output logic        [DATA_W-1:0] y_nxt
);

  localparam int ACC_W = 2 * DATA_W;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] prod;

  always_comb begin
    prod  = ACC_W'(a) * ACC_W'(b);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Arithmetic shift then truncate is just a bit window of the accumulator.
  assign y     = acc_q[FRAC_BITS +: DATA_W];
  assign y_nxt = acc_d[FRAC_BITS +: DATA_W];

endmodule

// File: rtl/iir_channel_sequencer.sv
// Walks the sample ROM once, running each sample through one shared first-order IIR MAC
// for ch0 then ch1; 10 cycles per sample, EMIT holds its word until out_ready.
module iir_channel_sequencer
  import filter_pkg::*;
#(
  parameter int                ADDR_W      = 15,
  parameter int                DATA_W      = 32,
  parameter int                FRAC_BITS   = 16,
  parameter int                NUM_SAMPLES = 20002,
  parameter logic [DATA_W-1:0] OUT_OFFSET  = 32'h003F_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              cfg_we,
  input  logic              cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ch,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

  seq_state_t state_q, state_d;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              ch_q, ch_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] x1_q, x1_d;
  logic [DATA_W-1:0] y1_q [2];
  logic [DATA_W-1:0] y1_d [2];
  coef_t             coef_q [2];
  coef_t             coef_d [2];
  logic              out_ch_q, out_ch_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic                     mac_clr;
  logic                     mac_en;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic        [DATA_W-1:0] mac_y;
  logic        [DATA_W-1:0] mac_y_nxt;

  logic accept;
  assign accept = (state_q == ST_EMIT) && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_B0;
      ST_B0:    state_d = ST_B1;
      ST_B1:    state_d = ST_A1;
      ST_A1:    state_d = ST_EMIT;
      ST_EMIT: begin
        if (out_ready) begin
          if (!ch_q) begin
            state_d = ST_B0;
          end else if (rom_addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs and MAC control
  always_comb begin
    busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done      = (state_q == ST_DONE);
    out_valid = (state_q == ST_EMIT);
    mac_clr   = (state_d == ST_B0) || ((state_q == ST_IDLE) && start);
    mac_en    = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    case (state_q)
      ST_B0: begin
        mac_en = 1'b1;
        mac_a  = coef_q[ch_q].b0;
        mac_b  = x_q;
      end
      ST_B1: begin
        mac_en = 1'b1;
        mac_a  = coef_q[ch_q].b1;
        mac_b  = x1_q;
      end
      ST_A1: begin
        mac_en = 1'b1;
        mac_a  = coef_q[ch_q].a1;
        mac_b  = y1_q[ch_q];
      end
      default: ;
    endcase
  end

  // Datapath, history and coefficient RAM
  always_comb begin
    rom_addr_d = rom_addr_q;
    ch_d       = ch_q;
    x_d        = x_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    coef_d     = coef_q;
    out_ch_d   = out_ch_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rom_addr_d = '0;
          ch_d       = 1'b0;
          x1_d       = '0;
          y1_d[0]    = '0;
          y1_d[1]    = '0;
        end
        if (cfg_we) begin
          case (coef_sel_t'(cfg_sel))
            SEL_B0:  coef_d[cfg_ch].b0 = cfg_data;
            SEL_B1:  coef_d[cfg_ch].b1 = cfg_data;
            SEL_A1:  coef_d[cfg_ch].a1 = cfg_data;
            default: ;
          endcase
        end
      end
      ST_WAIT: x_d = rom_q;
      // Capture the output word as the last product lands so it is stable for all of EMIT.
      ST_A1: begin
        out_ch_d   = ch_q;
        out_data_d = mac_y_nxt + OUT_OFFSET;
      end
      ST_EMIT: begin
        if (accept) begin
          y1_d[ch_q] = mac_y;
          if (!ch_q) begin
            ch_d = 1'b1;
          end else begin
            ch_d = 1'b0;
            x1_d = x_q;
            if (rom_addr_q != LAST_ADDR) begin
              rom_addr_d = rom_addr_q + ADDR_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_addr_q <= '0;
      ch_q       <= 1'b0;
      x_q        <= '0;
      x1_q       <= '0;
      y1_q[0]    <= '0;
      y1_q[1]    <= '0;
      coef_q[0]  <= LP_COEF_DEFAULT;
      coef_q[1]  <= HP_COEF_DEFAULT;
      out_ch_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      ch_q       <= ch_d;
      x_q        <= x_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      coef_q     <= coef_d;
      out_ch_q   <= out_ch_d;
      out_data_q <= out_data_d;
    end
  end

  iir_mac #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (mac_a),
    .b     (mac_b),
    .y     (mac_y),
    .y_nxt (mac_y_nxt)
  );

  assign rom_addr = rom_addr_q;
  assign out_ch   = out_ch_q;
  assign out_data = out_data_q;

endmodule
